// File: rtl/pe_accum_pipe.sv
// pe_accum_pipe
//   Dot-product processing element. Each accepted beat multiplies NUM_LANES
//   signed data/weight pairs and reduces the products into NUM_GROUPS partial
//   sums (stage 1). Stage 2 adds the group sums to either the bias (first beat)
//   or the running sum held in a local accumulator cache. Intermediate beats
//   write the running sum back to the cache; the last beat emits the result
//   and clears its cache entry.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input beat handshake (in_ready is the pipeline enable)
//   in_data, in_weights    packed signed lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_bias                signed bias, added on first beats only
//   in_first, in_last      accumulation start / finish markers
//   in_addr                accumulator cache entry for the beat
//   cfg_mode, cfg_shift    post-processing: raw, ReLU, requantise, requantise+ReLU
//   cache_clear            zero every cache entry at the clock edge
//   out_valid / out_ready  result handshake
//   out_acc                raw accumulated sum
//   out_act                post-processed activation
//   out_psum               group partial sums of the last emitted beat
module pe_accum_pipe #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_LANES   = 64,
  parameter int unsigned NUM_GROUPS  = 4,
  parameter int unsigned CACHE_DEPTH = 32,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned GRP_WIDTH   = 2*DATA_WIDTH + $clog2(NUM_LANES/NUM_GROUPS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]  in_weights,
  input  logic [DATA_WIDTH-1:0]            in_bias,
  input  logic                             in_first,
  input  logic                             in_last,
  input  logic [$clog2(CACHE_DEPTH)-1:0]   in_addr,
  input  logic [1:0]                       cfg_mode,
  input  logic [4:0]                       cfg_shift,
  input  logic                             cache_clear,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_WIDTH-1:0]             out_acc,
  output logic [DATA_WIDTH-1:0]            out_act,
  output logic [NUM_GROUPS*GRP_WIDTH-1:0]  out_psum
);

  localparam int unsigned LANES_PER_GRP = NUM_LANES / NUM_GROUPS;
  localparam int unsigned ADDR_WIDTH    = $clog2(CACHE_DEPTH);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    MODE_RAW     = 2'd0,
    MODE_RELU    = 2'd1,
    MODE_RQ      = 2'd2,
    MODE_RQ_RELU = 2'd3
  } mode_e;

  // Global stall: every pipeline register advances together.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------------------
  // Stage 1: lane products reduced per group
  // ---------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0]   lane_a;
  logic signed [DATA_WIDTH-1:0]   lane_b;
  logic signed [2*DATA_WIDTH-1:0] lane_p;
  logic signed [GRP_WIDTH-1:0]    grp_d [NUM_GROUPS];

  always_comb begin
    lane_a = '0;
    lane_b = '0;
    lane_p = '0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      grp_d[g] = '0;
      for (int unsigned l = 0; l < LANES_PER_GRP; l++) begin
        lane_a   = in_data[(g*LANES_PER_GRP + l)*DATA_WIDTH +: DATA_WIDTH];
        lane_b   = in_weights[(g*LANES_PER_GRP + l)*DATA_WIDTH +: DATA_WIDTH];
        lane_p   = lane_a * lane_b;
        grp_d[g] = grp_d[g] + GRP_WIDTH'(lane_p);
      end
    end
  end

  logic                          v1_q;
  logic                          first_q;
  logic                          last_q;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic signed [DATA_WIDTH-1:0]  bias_q;
  logic signed [GRP_WIDTH-1:0]   grp_q [NUM_GROUPS];

  // ---------------------------------------------------------------------------
  // Stage 2: accumulate against bias or cache, post-process
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0]         cache [CACHE_DEPTH];
  logic signed [ACC_WIDTH-1:0]  total;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic [DATA_WIDTH-1:0]        act_d;

  always_comb begin
    total = first_q ? ACC_WIDTH'(bias_q) : $signed(cache[addr_q]);
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      total = total + ACC_WIDTH'(grp_q[g]);
    end
  end

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    shifted = total >>> cfg_shift;
    act_d   = '0;
    case (mode_e'(cfg_mode))
      MODE_RAW:     act_d = total[DATA_WIDTH-1:0];
      MODE_RELU:    act_d = total[ACC_WIDTH-1]   ? '0 : sat(total);
      MODE_RQ:      act_d = sat(shifted);
      MODE_RQ_RELU: act_d = shifted[ACC_WIDTH-1] ? '0 : sat(shifted);
      default:      act_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      addr_q    <= '0;
      bias_q    <= '0;
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
        grp_q[g] <= '0;
      end
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_act   <= '0;
      out_psum  <= '0;
    end else if (en) begin
      v1_q    <= in_valid;
      first_q <= in_first;
      last_q  <= in_last;
      addr_q  <= in_addr;
      bias_q  <= in_bias;
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
        grp_q[g] <= grp_d[g];
      end
      // A consumed result drops here unless a new last beat replaces it.
      out_valid <= v1_q && last_q;
      if (v1_q && last_q) begin
        out_acc <= total;
        out_act <= act_d;
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
          out_psum[g*GRP_WIDTH +: GRP_WIDTH] <= grp_q[g];
        end
      end
    end
  end

  // Cache write lands at the edge after acceptance, so a back-to-back beat to
  // the same entry reads the updated value combinationally with no bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
        cache[i] <= '0;
      end
    end else if (cache_clear) begin
      for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
        cache[i] <= '0;
      end
    end else if (en && v1_q) begin
      cache[addr_q] <= last_q ? '0 : total;
    end
  end

endmodule

// File: tb/tb_pe_accum_pipe.sv
// Testbench for pe_accum_pipe: a reference model predicts every emitted result
// when a beat is accepted; a monitor pops and compares at each output handshake.
module tb_pe_accum_pipe;

  localparam int DW  = 8;
  localparam int NL  = 64;
  localparam int NG  = 4;
  localparam int CD  = 32;
  localparam int AW  = 32;
  localparam int LPG = NL / NG;
  localparam int GW  = 2*DW + $clog2(LPG);

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [NL*DW-1:0]     in_data;
  logic [NL*DW-1:0]     in_weights;
  logic [DW-1:0]        in_bias;
  logic                 in_first;
  logic                 in_last;
  logic [$clog2(CD)-1:0] in_addr;
  logic [1:0]           cfg_mode;
  logic [4:0]           cfg_shift;
  logic                 cache_clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [AW-1:0]        out_acc;
  logic [DW-1:0]        out_act;
  logic [NG*GW-1:0]     out_psum;

  typedef struct {
    int             acc;
    logic [DW-1:0]  act;
    logic [NG*GW-1:0] psum;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mcache[CD];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   acc_flag;

  pe_accum_pipe #(
    .DATA_WIDTH (DW),
    .NUM_LANES  (NL),
    .NUM_GROUPS (NG),
    .CACHE_DEPTH(CD),
    .ACC_WIDTH  (AW),
    .GRP_WIDTH  (GW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_weights (in_weights),
    .in_bias    (in_bias),
    .in_first   (in_first),
    .in_last    (in_last),
    .in_addr    (in_addr),
    .cfg_mode   (cfg_mode),
    .cfg_shift  (cfg_shift),
    .cache_clear(cache_clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_act    (out_act),
    .out_psum   (out_psum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- model
  function automatic int grp_sum(int g);
    int s, a, b;
    s = 0;
    for (int l = 0; l < LPG; l++) begin
      a = $signed(in_data[(g*LPG + l)*DW +: DW]);
      b = $signed(in_weights[(g*LPG + l)*DW +: DW]);
      s += a * b;
    end
    return s;
  endfunction

  function automatic int dot_now();
    int s;
    s = 0;
    for (int g = 0; g < NG; g++) s += grp_sum(g);
    return s;
  endfunction

  function automatic logic [DW-1:0] post(int t, logic [1:0] m, logic [4:0] sh);
    int s;
    if (m == 2'd0) return t[DW-1:0];
    s = m[1] ? (t >>> sh) : t;
    if (m != 2'd2 && s < 0) s = 0;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return s[DW-1:0];
  endfunction

  // Evaluated just before the rising edge: clear first, then the accepted beat.
  task automatic model_edge();
    int   gs[NG];
    int   tot;
    exp_t e;
    acc_flag = 1'b0;
    if (rst_n !== 1'b1) return;
    if (cache_clear) foreach (mcache[i]) mcache[i] = 0;
    if (in_valid && in_ready) begin
      acc_flag = 1'b1;
      tot = 0;
      for (int g = 0; g < NG; g++) begin
        gs[g] = grp_sum(g);
        tot += gs[g];
      end
      tot += in_first ? int'($signed(in_bias)) : mcache[in_addr];
      if (in_last) begin
        e.acc  = tot;
        e.act  = post(tot, cfg_mode, cfg_shift);
        e.psum = '0;
        for (int g = 0; g < NG; g++) e.psum[g*GW +: GW] = GW'(gs[g]);
        sb.push_back(e);
        mcache[in_addr] = 0;
      end else begin
        mcache[in_addr] = tot;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_result: got acc=%0d, required no result", $signed(out_acc));
      end else begin
        mon_e = sb.pop_front();
        vectors++;
        if ($signed(out_acc) !== mon_e.acc) begin
          miscompares++;
          $display("FAIL sb_acc: got %0d, required %0d", $signed(out_acc), mon_e.acc);
        end
        vectors++;
        if (out_act !== mon_e.act) begin
          miscompares++;
          $display("FAIL sb_act: got %0d, required %0d", $signed(out_act), $signed(mon_e.act));
        end
        vectors++;
        if (out_psum !== mon_e.psum) begin
          miscompares++;
          $display("FAIL sb_psum: got %h, required %h", out_psum, mon_e.psum);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_uniform(int dv, int wv);
    for (int i = 0; i < NL; i++) begin
      in_data[i*DW +: DW]    = DW'(dv);
      in_weights[i*DW +: DW] = DW'(wv);
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < NL; i++) begin
      in_data[i*DW +: DW]    = DW'($urandom);
      in_weights[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic present(bit f, bit l, int addr, int bias);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_addr  = addr[4:0];
    in_bias  = DW'(bias);
  endtask

  task automatic wait_accept(string name);
    for (int n = 0; n < 50; n++) begin
      step();
      if (acc_flag) break;
    end
    if (!acc_flag) begin
      vectors++; miscompares++;
      $display("FAIL %s_accept: got no acceptance in 50 cycles, required acceptance", name);
    end
    in_valid = 1'b0;
  endtask

  task automatic send(bit f, bit l, int addr, int bias, string name);
    present(f, l, addr, bias);
    wait_accept(name);
  endtask

  task automatic drain(string name);
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (sb.size() == 0 && out_valid === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d results outstanding, required 0", name, sb.size());
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    vectors++;
    if (out_acc !== '0) begin miscompares++; $display("FAIL reset_acc: got %h, required 0", out_acc); end
    vectors++;
    if (out_act !== '0) begin miscompares++; $display("FAIL reset_act: got %h, required 0", out_act); end
    vectors++;
    if (out_psum !== '0) begin miscompares++; $display("FAIL reset_psum: got %h, required 0", out_psum); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_single();
    cfg_mode = 2'd0; cfg_shift = 5'd0; out_ready = 1'b1;
    set_uniform(1, 1);
    send(1, 1, 0, 0, "single");
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid: got %b, required 0", out_valid); end
    step();
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b, required 1", out_valid); end
    vectors++;
    if (out_acc !== 32'd64) begin miscompares++; $display("FAIL single_acc: got %0d, required 64", out_acc); end
    vectors++;
    if (out_act !== 8'd64) begin miscompares++; $display("FAIL single_act: got %0d, required 64", out_act); end
    for (int g = 0; g < NG; g++) begin
      vectors++;
      if (out_psum[g*GW +: GW] !== GW'(16)) begin
        miscompares++;
        $display("FAIL single_psum%0d: got %0d, required 16", g, out_psum[g*GW +: GW]);
      end
    end
    drain("single");
  endtask

  task automatic test_accumulate();
    cfg_mode = 2'd2; cfg_shift = 5'd4; out_ready = 1'b1;
    set_uniform(2, 3);
    send(1, 0, 5, 10, "acc_b0");
    send(0, 0, 5, 0,  "acc_b1");
    send(0, 1, 5, 0,  "acc_b2");
    step();
    vectors++;
    if (out_acc !== 32'd1162) begin miscompares++; $display("FAIL accum_acc: got %0d, required 1162", out_acc); end
    vectors++;
    if (out_act !== 8'd72) begin miscompares++; $display("FAIL accum_act: got %0d, required 72", out_act); end
    set_uniform(0, 0);
    send(0, 1, 5, 0, "acc_zero");
    step();
    vectors++;
    if (out_acc !== 32'd0) begin miscompares++; $display("FAIL accum_cleared: got %0d, required 0", out_acc); end
    drain("accum");
  endtask

  task automatic test_saturation();
    cfg_mode = 2'd2; cfg_shift = 5'd0; out_ready = 1'b1;
    set_uniform(-128, 127);
    send(1, 1, 0, 0, "sat_rq");
    step();
    vectors++;
    if ($signed(out_acc) !== -1040384) begin miscompares++; $display("FAIL sat_acc: got %0d, required -1040384", $signed(out_acc)); end
    vectors++;
    if (out_act !== 8'h80) begin miscompares++; $display("FAIL sat_act: got %0d, required -128", $signed(out_act)); end
    cfg_mode = 2'd1;
    send(1, 1, 0, 0, "sat_relu");
    step();
    vectors++;
    if (out_act !== 8'd0) begin miscompares++; $display("FAIL sat_relu_act: got %0d, required 0", $signed(out_act)); end
    drain("sat");
  endtask

  task automatic test_backpressure();
    cfg_mode = 2'd1; cfg_shift = 5'd0; out_ready = 1'b0;
    set_uniform(1, 1);
    send(1, 1, 1, 3, "bp_a");
    set_uniform(2, 1);
    send(1, 0, 2, 0, "bp_b");
    set_uniform(1, 3);
    present(0, 1, 2, 0);
    for (int n = 0; n < 4; n++) begin
      step();
      vectors++;
      if (acc_flag || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_ready: got in_ready=%b, required 0", in_ready);
      end
      vectors++;
      if (out_valid !== 1'b1 || out_acc !== 32'd67) begin
        miscompares++;
        $display("FAIL bp_hold: got valid=%b acc=%0d, required valid=1 acc=67", out_valid, out_acc);
      end
    end
    out_ready = 1'b1;
    wait_accept("bp_c");
    step();
    vectors++;
    if (out_acc !== 32'd320 || out_act !== 8'd127) begin
      miscompares++;
      $display("FAIL bp_c_result: got acc=%0d act=%0d, required acc=320 act=127", out_acc, out_act);
    end
    drain("bp");
  endtask

  task automatic test_clear();
    int s31, own;
    cfg_mode = 2'd0; cfg_shift = 5'd0; out_ready = 1'b1;
    set_random(); send(1, 0, 0, 7, "clr_a0");
    set_random(); s31 = dot_now() - 20; send(1, 0, 31, -20, "clr_b0");
    set_random(); send(0, 0, 0, 0, "clr_a1");
    set_random(); s31 += dot_now(); send(0, 1, 31, 0, "clr_b1");
    step();
    vectors++;
    if ($signed(out_acc) !== s31) begin miscompares++; $display("FAIL clear_addr31: got %0d, required %0d", $signed(out_acc), s31); end
    set_random(); send(0, 0, 0, 0, "clr_a2");
    cache_clear = 1'b1;
    step();
    cache_clear = 1'b0;
    set_random(); own = dot_now(); send(0, 1, 0, 0, "clr_a3");
    step();
    vectors++;
    if ($signed(out_acc) !== own) begin miscompares++; $display("FAIL clear_addr0: got %0d, required %0d", $signed(out_acc), own); end
    drain("clear");
  endtask

  task automatic test_reset_mid();
    int own;
    cfg_mode = 2'd0; cfg_shift = 5'd0; out_ready = 1'b1;
    set_uniform(1, 2); send(1, 0, 7, 0, "rm_a");
    set_uniform(3, 1); send(1, 1, 3, 5, "rm_b");
    step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_acc !== '0 || out_act !== '0 || out_psum !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got valid=%b acc=%0d act=%0d psum=%h, required all 0",
               out_valid, out_acc, out_act, out_psum);
    end
    sb.delete();
    foreach (mcache[i]) mcache[i] = 0;
    step();
    step();
    rst_n = 1'b1;
    set_uniform(2, 2); own = dot_now();
    send(0, 1, 7, 0, "rm_c");
    step();
    vectors++;
    if ($signed(out_acc) !== own) begin miscompares++; $display("FAIL midreset_continue: got %0d, required %0d", $signed(out_acc), own); end
    drain("midreset");
  endtask

  task automatic test_random();
    for (int m = 0; m < 4; m++) begin
      cfg_mode  = m[1:0];
      cfg_shift = 5'($urandom_range(0, 12));
      for (int n = 0; n < 24; n++) begin
        if ($urandom_range(0, 1) == 1) begin
          out_ready = ($urandom_range(0, 1) == 1);
          step();
          out_ready = 1'b1;
        end
        set_random();
        send($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3), $urandom_range(0, 255), "rnd");
      end
      drain("rnd");
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_weights = '0; in_bias = '0;
    in_first = 1'b0; in_last = 1'b0; in_addr = '0; cfg_mode = 2'd0; cfg_shift = 5'd0;
    cache_clear = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    step();
    test_single();
    test_accumulate();
    test_saturation();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
